// File: rtl/vga_pkg.sv
// vga_pkg: shared types and timing presets for the VGA timing generator.
//   vga_timing_t  : one axis of a video timing set (active/front porch/sync/back porch)
//   vga_sig_t     : per-pixel sync/display levels carried down the output delay line
//   run_state_t   : run/park state of the generator
package vga_pkg;

   typedef struct packed {
      logic [15:0] act;
      logic [15:0] fp;
      logic [15:0] sync;
      logic [15:0] bp;
   } vga_timing_t;

   typedef struct packed {
      logic hs;
      logic vs;
      logic disp;
   } vga_sig_t;

   typedef enum logic {
      ST_PARK = 1'b0,
      ST_RUN  = 1'b1
   } run_state_t;

   // 640x480@60 (25 MHz pixel)
   localparam vga_timing_t VGA_640X480_H = '{act: 16'd640, fp: 16'd16, sync: 16'd96,  bp: 16'd48};
   localparam vga_timing_t VGA_640X480_V = '{act: 16'd480, fp: 16'd10, sync: 16'd2,   bp: 16'd33};

   // 800x600@60 (40 MHz pixel)
   localparam vga_timing_t VGA_800X600_H = '{act: 16'd800, fp: 16'd40, sync: 16'd128, bp: 16'd88};
   localparam vga_timing_t VGA_800X600_V = '{act: 16'd600, fp: 16'd1,  sync: 16'd4,   bp: 16'd23};

   function automatic int timing_total(input vga_timing_t t);
      return int'(t.act) + int'(t.fp) + int'(t.sync) + int'(t.bp);
   endfunction

endpackage

// File: rtl/vga_sig_delay.sv
// vga_sig_delay: LAT-deep delay line of vga_sig_t, advancing only on ce.
//   Clk     : system clock
//   Reset_n : asynchronous reset, active-low; every stage loads rst_val
//   ce      : shift enable (pixel tick)
//   rst_val : idle/blank value used on reset
//   d / q   : line input / output of the last stage (registered)
module vga_sig_delay
   import vga_pkg::*;
#(
   parameter int LAT = 1
) (
   input  logic     Clk,
   input  logic     Reset_n,
   input  logic     ce,
   input  vga_sig_t rst_val,
   input  vga_sig_t d,
   output vga_sig_t q
);

   vga_sig_t stage [LAT];

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         for (int i = 0; i < LAT; i++) stage[i] <= rst_val;
      end else if (ce) begin
         stage[0] <= d;
         for (int i = 1; i < LAT; i++) stage[i] <= stage[i-1];
      end
   end

   assign q = stage[LAT-1];

endmodule

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: parametrised VGA timing generator on a single clock with a
// pixel clock enable, programmable sync/blank latency and run/park control.
//   Clk, Reset_n        : system clock, asynchronous active-low reset
//   En                  : run enable, taken only at a frame boundary
//   pixel_ce            : one-Clk pixel tick every CLK_DIV cycles
//   DrawX, DrawY        : current pixel coordinate
//   hs, vs, blank       : registered syncs/display flag, LAT ticks behind DrawX/DrawY
//   sync                : composite sync (unused, 0)
//   line_start          : 1-Clk strobe when DrawX shows 0
//   frame_start         : 1-Clk strobe when (DrawX,DrawY) shows (0,0)
//   frame_cnt           : completed frames
//
// state   | meaning
// ST_PARK | counters held at (0,0), outputs idle, En sampled every pixel tick
// ST_RUN  | counters scanning; En sampled only at the (0,0) wrap
module vga_timing_gen
   import vga_pkg::*;
#(
   parameter int H_ACT   = int'(VGA_640X480_H.act),
   parameter int H_FP    = int'(VGA_640X480_H.fp),
   parameter int H_SYNC  = int'(VGA_640X480_H.sync),
   parameter int H_BP    = int'(VGA_640X480_H.bp),
   parameter int V_ACT   = int'(VGA_640X480_V.act),
   parameter int V_FP    = int'(VGA_640X480_V.fp),
   parameter int V_SYNC  = int'(VGA_640X480_V.sync),
   parameter int V_BP    = int'(VGA_640X480_V.bp),
   parameter bit HS_POL  = 1'b0,
   parameter bit VS_POL  = 1'b0,
   parameter int CLK_DIV = 2,
   parameter int LAT     = 1,
   parameter int CW      = 10
) (
   input  logic          Clk,
   input  logic          Reset_n,
   input  logic          En,
   output logic          pixel_ce,
   output logic [CW-1:0] DrawX,
   output logic [CW-1:0] DrawY,
   output logic          hs,
   output logic          vs,
   output logic          blank,
   output logic          sync,
   output logic          line_start,
   output logic          frame_start,
   output logic [15:0]   frame_cnt
);

   localparam vga_timing_t H_T = '{act: 16'(H_ACT), fp: 16'(H_FP), sync: 16'(H_SYNC), bp: 16'(H_BP)};
   localparam vga_timing_t V_T = '{act: 16'(V_ACT), fp: 16'(V_FP), sync: 16'(V_SYNC), bp: 16'(V_BP)};
   localparam int H_TOT = timing_total(H_T);
   localparam int V_TOT = timing_total(V_T);

   localparam logic [CW-1:0] X_LAST = CW'(H_TOT - 1);
   localparam logic [CW-1:0] Y_LAST = CW'(V_TOT - 1);
   localparam logic [CW-1:0] X_ACT  = CW'(H_ACT);
   localparam logic [CW-1:0] Y_ACT  = CW'(V_ACT);
   localparam logic [CW-1:0] HS_BEG = CW'(H_ACT + H_FP);
   localparam logic [CW-1:0] HS_END = CW'(H_ACT + H_FP + H_SYNC);
   localparam logic [CW-1:0] VS_BEG = CW'(V_ACT + V_FP);
   localparam logic [CW-1:0] VS_END = CW'(V_ACT + V_FP + V_SYNC);
   localparam logic [4:0]    DIV_LAST = 5'(CLK_DIV - 1);

   localparam vga_sig_t SIG_IDLE = '{hs: ~HS_POL, vs: ~VS_POL, disp: 1'b0};

   if (H_TOT > 2**CW) begin : g_bad_htot
      $error("vga_timing_gen: H_TOT=%0d does not fit in CW=%0d bits", H_TOT, CW);
   end
   if (V_TOT > 2**CW) begin : g_bad_vtot
      $error("vga_timing_gen: V_TOT=%0d does not fit in CW=%0d bits", V_TOT, CW);
   end
   if (CLK_DIV < 1 || CLK_DIV > 16) begin : g_bad_div
      $error("vga_timing_gen: CLK_DIV=%0d outside 1..16", CLK_DIV);
   end
   if (LAT < 1 || LAT > 8) begin : g_bad_lat
      $error("vga_timing_gen: LAT=%0d outside 1..8", LAT);
   end

   logic [4:0] div_cnt;
   run_state_t state;
   logic       seen_frame;
   vga_sig_t   sig_raw;
   vga_sig_t   sig_out;

   // pixel_ce is registered from the count, so it is low throughout reset even
   // when CLK_DIV=1 and the first tick lands CLK_DIV edges after release.
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         div_cnt  <= '0;
         pixel_ce <= 1'b0;
      end else begin
         pixel_ce <= (div_cnt == DIV_LAST);
         div_cnt  <= (div_cnt == DIV_LAST) ? 5'd0 : div_cnt + 5'd1;
      end
   end

   // Frame counting skips the first frame_start after reset; every later one
   // marks the end of a completed frame (including the frame before a park).
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         state       <= ST_PARK;
         DrawX       <= '0;
         DrawY       <= '0;
         line_start  <= 1'b0;
         frame_start <= 1'b0;
         frame_cnt   <= '0;
         seen_frame  <= 1'b0;
      end else begin
         line_start  <= 1'b0;
         frame_start <= 1'b0;
         if (pixel_ce) begin
            case (state)
               ST_PARK: begin
                  if (En) begin
                     state       <= ST_RUN;
                     line_start  <= 1'b1;
                     frame_start <= 1'b1;
                     seen_frame  <= 1'b1;
                     if (seen_frame) frame_cnt <= frame_cnt + 16'd1;
                  end
               end
               ST_RUN: begin
                  if (DrawX == X_LAST) begin
                     DrawX <= '0;
                     if (DrawY == Y_LAST) begin
                        DrawY <= '0;
                        if (En) begin
                           line_start  <= 1'b1;
                           frame_start <= 1'b1;
                           frame_cnt   <= frame_cnt + 16'd1;
                        end else begin
                           state <= ST_PARK;
                        end
                     end else begin
                        DrawY      <= DrawY + CW'(1);
                        line_start <= 1'b1;
                     end
                  end else begin
                     DrawX <= DrawX + CW'(1);
                  end
               end
               default: state <= ST_PARK;
            endcase
         end
      end
   end

   always_comb begin
      sig_raw = SIG_IDLE;
      if (state == ST_RUN) begin
         sig_raw.hs   = (DrawX >= HS_BEG && DrawX < HS_END) ? HS_POL : ~HS_POL;
         sig_raw.vs   = (DrawY >= VS_BEG && DrawY < VS_END) ? VS_POL : ~VS_POL;
         sig_raw.disp = (DrawX < X_ACT) && (DrawY < Y_ACT);
      end
   end

   vga_sig_delay #(.LAT(LAT)) u_delay (
      .Clk     (Clk),
      .Reset_n (Reset_n),
      .ce      (pixel_ce),
      .rst_val (SIG_IDLE),
      .d       (sig_raw),
      .q       (sig_out)
   );

   assign hs    = sig_out.hs;
   assign vs    = sig_out.vs;
   assign blank = sig_out.disp;
   assign sync  = 1'b0;

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
- Parametrised successor to the fixed 640x480 VGA controller: generates hs, vs, blank, sync and DrawX/DrawY for any timing set.
- Uses a clock enable (pixel_ce) instead of a divided clock, so the whole design stays on Clk.
- Adds a programmable output latency so syncs and blank line up with a downstream colour/sprite pipeline.
- Adds a run/stop enable and frame/line strobes for frame-synchronous logic such as game-state update and frame-buffer swap.

Parameters:
- H_ACT, 640, active pixels per line.
- H_FP, 16, horizontal front porch (pixels).
- H_SYNC, 96, horizontal sync width (pixels).
- H_BP, 48, horizontal back porch (pixels).
- V_ACT, 480, active lines per frame.
- V_FP, 10, vertical front porch (lines).
- V_SYNC, 2, vertical sync width (lines).
- V_BP, 33, vertical back porch (lines).
- HS_POL, 0, active level of hs.
- VS_POL, 0, active level of vs.
- CLK_DIV, 2, Clk cycles per pixel tick; legal range 1..16.
- LAT, 1, pixel ticks from coordinate output to matching hs/vs/blank output; legal range 1..8.
- CW, 10, width of DrawX/DrawY.

Ports:
- Clk  in  1  system clock (50 MHz on DE2)
- Reset_n  in  1  asynchronous reset, active-low
- En  in  1  run enable, sampled only at frame boundary
- pixel_ce  out  1  one-Clk-wide pixel tick, every CLK_DIV cycles
- DrawX  out  CW  current horizontal counter
- DrawY  out  CW  current vertical counter
- hs  out  1  horizontal sync, registered, polarity HS_POL
- vs  out  1  vertical sync, registered, polarity VS_POL
- blank  out  1  active-low blanking (1 = display pixel)
- sync  out  1  composite sync, tied 0
- line_start  out  1  pulse on the pixel_ce where DrawX becomes 0
- frame_start  out  1  pulse on the pixel_ce where (DrawX,DrawY) becomes (0,0)
- frame_cnt  out  16  completed-frame counter

Behaviour:
- Derived totals: H_TOT = H_ACT+H_FP+H_SYNC+H_BP (default 800); V_TOT likewise (default 525).
- Reset (Reset_n=0, asynchronous) forces:
  - divider count 0, pixel_ce 0;
  - DrawX and DrawY 0;
  - hs = ~HS_POL, vs = ~VS_POL, blank 0;
  - every pipeline stage cleared to the inactive/blank value;
  - line_start 0, frame_start 0, frame_cnt 0;
  - running flag 0.
- Divider:
  - counts 0..CLK_DIV-1; pixel_ce=1 on the cycle the count equals CLK_DIV-1.
  - CLK_DIV=1 gives pixel_ce constantly 1 after reset release.
- Counters advance only on pixel_ce:
  - DrawX wraps H_TOT-1 -> 0; DrawY increments on each DrawX wrap.
  - DrawY wraps V_TOT-1 -> 0.
- Run control:
  - The running flag loads En only on the pixel_ce where the counters wrap to (0,0), or on the first pixel_ce after reset.
  - While not running, counters hold at (0,0), blank=0, hs/vs inactive, and no strobes are produced.
  - Dropping En mid-frame completes the current frame, then parks.
- Raw timing per coordinate (combinational from counters):
  - hs_raw active iff H_ACT+H_FP <= DrawX < H_ACT+H_FP+H_SYNC.
  - vs_raw active iff V_ACT+V_FP <= DrawY < V_ACT+V_FP+V_SYNC.
  - disp_raw iff DrawX < H_ACT and DrawY < V_ACT.
- Pipeline:
  - The raw values pass through a LAT-deep shift register advancing on pixel_ce.
  - hs/vs/blank therefore describe the coordinate that was on DrawX/DrawY LAT pixel ticks earlier.
  - Outputs are registered, with no combinational path to the pins.
- Strobes:
  - line_start and frame_start are registered, 1 Clk wide, asserted in the same cycle DrawX (or DrawX,DrawY) shows 0.
  - frame_cnt increments, wrapping at 2^16, in the same cycle frame_start is asserted.
  - The first frame after reset does not increment frame_cnt.
- Widths: all comparisons are done at CW bits. Elaboration fails via an $error check if H_TOT or V_TOT exceeds 2^CW.

Decomposition:
- Package vga_pkg holds:
  - timing parameter defaults for 640x480@60;
  - an optional 800x600 set;
  - typedef vga_timing_t, a struct of act/fp/sync/bp;
  - typedef vga_sig_t {hs, vs, disp}, used as the pipeline element.
- Sub-module vga_sig_delay: generic LAT-deep, clock-enabled delay line of vga_sig_t with a reset value input.

Test Plan:
- Default params, release reset:
  - pixel_ce every 2nd Clk;
  - DrawX runs 0..799;
  - a line is 1600 Clk; a frame is 840000 Clk.
- Default, LAT=1:
  - hs low for exactly 96 ticks, starting one tick after DrawX=656;
  - vs low for 2 lines, starting one tick after (DrawX=0, DrawY=490);
  - blank=1 for 640 of every 800 ticks on lines 0..479 only.
- LAT=4:
  - hs falls 4 ticks after DrawX=656;
  - blank rises 4 ticks after DrawX=0 on line 0.
- CLK_DIV=1 with tiny timing (H 8/1/2/1, V 4/1/1/1):
  - line=12 Clk, frame=84 Clk;
  - frame_start every 84 Clk;
  - frame_cnt=3 after 4 frames.
- En dropped at DrawY=100:
  - frame completes, counters park at (0,0), blank=0, hs/vs high, no strobes.
- En raised:
  - restart at the next boundary; frame_cnt resumes.
- Reset_n pulsed low mid-line (DrawX=300, DrawY=200):
  - all outputs at reset values immediately (async, not waiting for a Clk edge).
- Reset_n released:
  - the first pixel_ce occurs CLK_DIV Clk later.
